// File: rtl/sccb_pkg.sv
`timescale 1ns/1ps
// Shared types and constants for the SCCB responder.
package sccb_pkg;

    localparam int unsigned SCCB_BITS     = 8;
    localparam logic [6:0]  SCCB_DEV_ADDR = 7'h21;
    localparam logic [7:0]  SCCB_WR_ID    = {SCCB_DEV_ADDR, 1'b0};
    localparam logic [7:0]  SCCB_RD_ID    = {SCCB_DEV_ADDR, 1'b1};

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_DEV       = 4'd1,
        ST_DEV_ACK   = 4'd2,
        ST_SUB       = 4'd3,
        ST_SUB_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8,
        ST_IGNORE    = 4'd9
    } sccb_state_e;

endpackage

// File: rtl/sccb_line_sync.sv
`timescale 1ns/1ps
// Synchronizes SCL/SDA into the clk domain and emits single-cycle
// SCL edge, START and STOP pulses. START/STOP mask a same-cycle SCL edge.
module sccb_line_sync (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic start_det,
    output logic stop_det,
    output logic sda_bit
);

    logic scl_meta_r, scl_sync_r, scl_dly_r;
    logic sda_meta_r, sda_sync_r, sda_dly_r;
    logic scl_rise_r, scl_fall_r, start_r, stop_r, sda_bit_r;
    logic start_s, stop_s, rise_s, fall_s;

    // Decode bus conditions from the synchronized and delayed line values.
    always_comb begin
        start_s = scl_sync_r & scl_dly_r & sda_dly_r & ~sda_sync_r;
        stop_s  = scl_sync_r & scl_dly_r & ~sda_dly_r & sda_sync_r;
        if (start_s || stop_s) begin
            rise_s = 1'b0;
            fall_s = 1'b0;
        end else begin
            rise_s = scl_sync_r & ~scl_dly_r;
            fall_s = ~scl_sync_r & scl_dly_r;
        end
    end

    // Synchronizer chains (idle-high bus) and registered event pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            scl_meta_r <= 1'b1;
            scl_sync_r <= 1'b1;
            scl_dly_r  <= 1'b1;
            sda_meta_r <= 1'b1;
            sda_sync_r <= 1'b1;
            sda_dly_r  <= 1'b1;
            scl_rise_r <= 1'b0;
            scl_fall_r <= 1'b0;
            start_r    <= 1'b0;
            stop_r     <= 1'b0;
            sda_bit_r  <= 1'b1;
        end else begin
            scl_meta_r <= scl_i;
            scl_sync_r <= scl_meta_r;
            scl_dly_r  <= scl_sync_r;
            sda_meta_r <= sda_i;
            sda_sync_r <= sda_meta_r;
            sda_dly_r  <= sda_sync_r;
            scl_rise_r <= rise_s;
            scl_fall_r <= fall_s;
            start_r    <= start_s;
            stop_r     <= stop_s;
            sda_bit_r  <= sda_sync_r;
        end
    end

    assign scl_rise  = scl_rise_r;
    assign scl_fall  = scl_fall_r;
    assign start_det = start_r;
    assign stop_det  = stop_r;
    assign sda_bit   = sda_bit_r;

endmodule

// File: rtl/sccb_responder.sv
`timescale 1ns/1ps
// SCCB target emulating the OV7670 configuration port: register writes
// through a strobe port, reads from a combinational register-file port.
module sccb_responder
    import sccb_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = SCCB_DEV_ADDR
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe,
    output logic       reg_wr_en,
    output logic [7:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic [7:0] reg_rd_addr,
    input  logic [7:0] reg_rd_data,
    output logic       busy
);

    localparam logic [3:0] BIT_LAST = 4'(SCCB_BITS - 1);
    localparam logic [3:0] BIT_FULL = 4'(SCCB_BITS);

    logic        rise_s, fall_s, start_s, stop_s, sda_bit_s;
    sccb_state_e state_r, state_s;
    logic [3:0]  bit_cnt_r, bit_cnt_s;
    logic [7:0]  shift_r, shift_s, byte_s;
    logic [7:0]  ptr_r, ptr_s;
    logic        sda_oe_r, sda_oe_s;
    logic        wr_en_r, wr_en_s;
    logic [7:0]  wr_addr_r, wr_addr_s, wr_data_r, wr_data_s;
    logic        busy_r, busy_s;

    sccb_line_sync u_line_sync (
        .clk       (clk),
        .rst       (rst),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (rise_s),
        .scl_fall  (fall_s),
        .start_det (start_s),
        .stop_det  (stop_s),
        .sda_bit   (sda_bit_s)
    );

    // Next-state and output logic; bits sampled on SCL rise, SDA driven on SCL fall.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        shift_s   = shift_r;
        ptr_s     = ptr_r;
        sda_oe_s  = sda_oe_r;
        wr_en_s   = 1'b0;
        wr_addr_s = wr_addr_r;
        wr_data_s = wr_data_r;
        busy_s    = busy_r;
        byte_s    = {shift_r[6:0], sda_bit_s};
        if (start_s) begin
            state_s   = ST_DEV;
            bit_cnt_s = 4'd0;
            sda_oe_s  = 1'b0;
        end else if (stop_s) begin
            state_s   = ST_IDLE;
            bit_cnt_s = 4'd0;
            sda_oe_s  = 1'b0;
            busy_s    = 1'b0;
        end else if (rise_s) begin
            case (state_r)
                ST_DEV, ST_SUB, ST_WDATA: begin
                    shift_s = byte_s;
                    if (bit_cnt_r == BIT_LAST) begin
                        bit_cnt_s = 4'd0;
                        if (state_r == ST_DEV) begin
                            if (byte_s[7:1] == DEV_ADDR) begin
                                state_s = ST_DEV_ACK;
                                busy_s  = 1'b1;
                            end else begin
                                state_s = ST_IGNORE;
                            end
                        end else if (state_r == ST_SUB) begin
                            ptr_s   = byte_s;
                            state_s = ST_SUB_ACK;
                        end else begin
                            wr_en_s   = 1'b1;
                            wr_addr_s = ptr_r;
                            wr_data_s = byte_s;
                            ptr_s     = ptr_r + 8'd1;
                            state_s   = ST_WDATA_ACK;
                        end
                    end else begin
                        bit_cnt_s = bit_cnt_r + 4'd1;
                    end
                end
                ST_RDATA: begin
                    bit_cnt_s = bit_cnt_r + 4'd1;
                end
                ST_RDATA_ACK: begin
                    ptr_s = ptr_r + 8'd1;
                    if (sda_bit_s) begin
                        state_s = ST_IGNORE;
                    end else begin
                        bit_cnt_s = 4'd1;
                    end
                end
                default: begin
                    state_s = state_r;
                end
            endcase
        end else if (fall_s) begin
            case (state_r)
                ST_DEV_ACK, ST_SUB_ACK, ST_WDATA_ACK: begin
                    // bit_cnt 0: start driving ACK; 1: ACK clock finished.
                    if (bit_cnt_r == 4'd0) begin
                        sda_oe_s  = 1'b1;
                        bit_cnt_s = 4'd1;
                    end else begin
                        sda_oe_s  = 1'b0;
                        bit_cnt_s = 4'd0;
                        if (state_r == ST_DEV_ACK && shift_r[0]) begin
                            shift_s  = reg_rd_data;
                            sda_oe_s = ~reg_rd_data[7];
                            state_s  = ST_RDATA;
                        end else if (state_r == ST_DEV_ACK) begin
                            state_s = ST_SUB;
                        end else begin
                            state_s = ST_WDATA;
                        end
                    end
                end
                ST_RDATA: begin
                    if (bit_cnt_r == BIT_FULL) begin
                        sda_oe_s  = 1'b0;
                        bit_cnt_s = 4'd0;
                        state_s   = ST_RDATA_ACK;
                    end else begin
                        shift_s  = {shift_r[6:0], 1'b0};
                        sda_oe_s = ~shift_r[6];
                    end
                end
                ST_RDATA_ACK: begin
                    // bit_cnt 1 marks a master ACK seen on the 9th rise.
                    if (bit_cnt_r == 4'd1) begin
                        shift_s   = reg_rd_data;
                        sda_oe_s  = ~reg_rd_data[7];
                        bit_cnt_s = 4'd0;
                        state_s   = ST_RDATA;
                    end else begin
                        state_s = state_r;
                    end
                end
                default: begin
                    state_s = state_r;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            bit_cnt_r <= 4'd0;
            shift_r   <= 8'h00;
            ptr_r     <= 8'h00;
            sda_oe_r  <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= 8'h00;
            wr_data_r <= 8'h00;
            busy_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            shift_r   <= shift_s;
            ptr_r     <= ptr_s;
            sda_oe_r  <= sda_oe_s;
            wr_en_r   <= wr_en_s;
            wr_addr_r <= wr_addr_s;
            wr_data_r <= wr_data_s;
            busy_r    <= busy_s;
        end
    end

    assign sda_oe      = sda_oe_r;
    assign reg_wr_en   = wr_en_r;
    assign reg_wr_addr = wr_addr_r;
    assign reg_wr_data = wr_data_r;
    assign reg_rd_addr = ptr_r;
    assign busy        = busy_r;

endmodule
